// File: rtl/stack_seq.sv
// Command sequencer in front of the 2-bit stack: PUSH/POP/PEEK/NOP over valid/ready, one response per command.
// Optional saturating error counter enabled by defining STACK_SEQ_ERRCNT_EN.
module stack_seq #(
    parameter int DATA_W = 2,
    parameter int ERR_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [DATA_W-1:0] CMD_DATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_ERR,
    output logic              STK_PUSH,
    output logic              STK_POP,
    output logic [DATA_W-1:0] STK_DATA_IN,
    input  logic [DATA_W-1:0] STK_DATA_OUT,
    input  logic              STK_FULL,
    input  logic              STK_EMPTY,
    output logic [ERR_W-1:0]  ERR_CNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_PEEK = 2'b11
    } op_t;

    state_t            state, state_nx;
    op_t               op_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              push_d, pop_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q       <= OP_NOP;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (state == S_IDLE && CMD_VALID) begin
                op_q   <= op_t'(CMD_OP);
                data_q <= CMD_DATA;
            end
            if (state == S_EXEC) begin
                rsp_data_q <= rsp_data_d;
                rsp_err_q  <= rsp_err_d;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        CMD_READY  = 1'b0;
        RSP_VALID  = 1'b0;
        push_d     = 1'b0;
        pop_d      = 1'b0;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        case (state)
            S_IDLE: begin
                CMD_READY = 1'b1;
                if (CMD_VALID) state_nx = S_EXEC;
            end
            S_EXEC: begin
                state_nx = S_RESP;
                // Flags are checked here so an illegal strobe never reaches the stack.
                case (op_q)
                    OP_PUSH: begin
                        if (!STK_FULL) push_d    = 1'b1;
                        else           rsp_err_d = 1'b1;
                    end
                    OP_POP: begin
                        if (!STK_EMPTY) begin
                            pop_d      = 1'b1;
                            rsp_data_d = STK_DATA_OUT;
                        end else begin
                            rsp_err_d = 1'b1;
                        end
                    end
                    OP_PEEK: begin
                        if (!STK_EMPTY) rsp_data_d = STK_DATA_OUT;
                        else            rsp_err_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_RESP: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Reset gates the strobes combinationally so none escapes while RST is high.
    assign STK_PUSH    = push_d & ~RST;
    assign STK_POP     = pop_d & ~RST;
    assign STK_DATA_IN = data_q;
    assign RSP_DATA    = rsp_data_q;
    assign RSP_ERR     = rsp_err_q;

`ifdef STACK_SEQ_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_cnt_q <= '0;
        end else if (state == S_EXEC && rsp_err_d && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
    end

    assign ERR_CNT = err_cnt_q;
`else
    assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq against a 4-deep behavioural stack model.
module tb_stack_seq;

    localparam int DATA_W = 2;
    localparam int ERR_W  = 8;
`ifdef STACK_SEQ_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              CMD_VALID = 1'b0;
    logic              CMD_READY;
    logic [1:0]        CMD_OP = 2'b00;
    logic [DATA_W-1:0] CMD_DATA = '0;
    logic              RSP_VALID;
    logic              RSP_READY = 1'b1;
    logic [DATA_W-1:0] RSP_DATA;
    logic              RSP_ERR;
    logic              STK_PUSH;
    logic              STK_POP;
    logic [DATA_W-1:0] STK_DATA_IN;
    logic [DATA_W-1:0] STK_DATA_OUT;
    logic              STK_FULL;
    logic              STK_EMPTY;
    logic [ERR_W-1:0]  ERR_CNT;

    int checks = 0;
    int errors = 0;
    int push_pulses = 0;
    int pop_pulses = 0;

    stack_seq #(.DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .STK_PUSH(STK_PUSH), .STK_POP(STK_POP), .STK_DATA_IN(STK_DATA_IN),
        .STK_DATA_OUT(STK_DATA_OUT), .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY),
        .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    // Stack model; its RST_N is ~RST, so it clears together with the sequencer.
    logic [DATA_W-1:0] mem [4];
    logic [2:0]        cnt = 3'd0;

    always @(posedge CLK) begin
        if (RST) begin
            cnt <= 3'd0;
        end else if (STK_PUSH && cnt < 3'd4) begin
            mem[cnt[1:0]] <= STK_DATA_IN;
            cnt           <= cnt + 3'd1;
        end else if (STK_POP && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
        if (STK_PUSH) push_pulses++;
        if (STK_POP)  pop_pulses++;
    end

    assign STK_FULL     = (cnt == 3'd4);
    assign STK_EMPTY    = (cnt == 3'd0);
    assign STK_DATA_OUT = (cnt != 3'd0) ? mem[cnt[1:0] - 2'd1] : '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_errcnt(input string tag, input int exp);
        check(tag, 32'(ERR_CNT), ERRCNT ? 32'(exp) : 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge CLK);
        while (!CMD_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_ready"}, 32'(CMD_READY), 32'd1);
    endtask

    // Full command with RSP_READY high: accept, EXEC, RESP, back to IDLE.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [1:0] d,
                          input logic [1:0] exp_data, input logic exp_err);
        int  pp0, po0;
        logic exp_push, exp_pop;
        exp_push = (op == 2'b01) && !exp_err;
        exp_pop  = (op == 2'b10) && !exp_err;
        wait_ready(tag);
        pp0 = push_pulses;
        po0 = pop_pulses;
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_DATA  = d;
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        check({tag, "_exec_push"}, 32'(STK_PUSH), 32'(exp_push));
        check({tag, "_exec_pop"}, 32'(STK_POP), 32'(exp_pop));
        check({tag, "_exec_din"}, 32'(STK_DATA_IN), 32'(d));
        check({tag, "_exec_cmdrdy"}, 32'(CMD_READY), 32'd0);
        @(posedge CLK); #1;
        check({tag, "_rsp_valid"}, 32'(RSP_VALID), 32'd1);
        check({tag, "_rsp_data"}, 32'(RSP_DATA), 32'(exp_data));
        check({tag, "_rsp_err"}, 32'(RSP_ERR), 32'(exp_err));
        check({tag, "_rsp_strobes"}, 32'(STK_PUSH | STK_POP), 32'd0);
        @(posedge CLK); #1;
        check({tag, "_done_valid"}, 32'(RSP_VALID), 32'd0);
        check({tag, "_done_ready"}, 32'(CMD_READY), 32'd1);
        check({tag, "_push_pulses"}, 32'(push_pulses - pp0), 32'(exp_push));
        check({tag, "_pop_pulses"}, 32'(pop_pulses - po0), 32'(exp_pop));
    endtask

    initial begin
        int po0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_cmd_ready", 32'(CMD_READY), 32'd1);
        check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        check("rst_rsp_data", 32'(RSP_DATA), 32'd0);
        check("rst_rsp_err", 32'(RSP_ERR), 32'd0);
        check("rst_strobes", 32'(STK_PUSH | STK_POP), 32'd0);
        check("rst_din", 32'(STK_DATA_IN), 32'd0);
        check("rst_errcnt", 32'(ERR_CNT), 32'd0);

        do_cmd("push2", 2'b01, 2'd2, 2'd0, 1'b0);
        do_cmd("pop2", 2'b10, 2'd0, 2'd2, 1'b0);

        do_cmd("push1", 2'b01, 2'd1, 2'd0, 1'b0);
        do_cmd("push2b", 2'b01, 2'd2, 2'd0, 1'b0);
        do_cmd("push3", 2'b01, 2'd3, 2'd0, 1'b0);
        do_cmd("pop3", 2'b10, 2'd0, 2'd3, 1'b0);
        do_cmd("pop2b", 2'b10, 2'd0, 2'd2, 1'b0);
        do_cmd("pop1", 2'b10, 2'd0, 2'd1, 1'b0);

        do_cmd("pop_empty", 2'b10, 2'd3, 2'd0, 1'b1);
        check_errcnt("errcnt_pop_empty", 1);
        do_cmd("nop", 2'b00, 2'd3, 2'd0, 1'b0);

        do_cmd("fill0", 2'b01, 2'd0, 2'd0, 1'b0);
        do_cmd("fill1", 2'b01, 2'd1, 2'd0, 1'b0);
        do_cmd("fill2", 2'b01, 2'd2, 2'd0, 1'b0);
        do_cmd("fill3", 2'b01, 2'd3, 2'd0, 1'b0);
        check("full_flag", 32'(STK_FULL), 32'd1);
        do_cmd("push_full", 2'b01, 2'd1, 2'd0, 1'b1);
        check_errcnt("errcnt_push_full", 2);
        do_cmd("peek_full", 2'b11, 2'd0, 2'd3, 1'b0);
        check("peek_depth", 32'(cnt), 32'd4);

        // Response backpressure: RSP_READY low for five RESP cycles.
        wait_ready("bp");
        po0 = pop_pulses;
        RSP_READY = 1'b0;
        CMD_VALID = 1'b1;
        CMD_OP    = 2'b10;
        CMD_DATA  = 2'd0;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        check("bp_exec_pop", 32'(STK_POP), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check("bp_valid", 32'(RSP_VALID), 32'd1);
            check("bp_data", 32'(RSP_DATA), 32'd3);
            check("bp_err", 32'(RSP_ERR), 32'd0);
            check("bp_cmd_ready", 32'(CMD_READY), 32'd0);
        end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        check("bp_release_valid", 32'(RSP_VALID), 32'd0);
        check("bp_release_ready", 32'(CMD_READY), 32'd1);
        check("bp_pop_pulses", 32'(pop_pulses - po0), 32'd1);
        check("bp_depth", 32'(cnt), 32'd3);

        // Reset asserted during the EXEC cycle of a POP.
        wait_ready("rstx");
        po0 = pop_pulses;
        CMD_VALID = 1'b1;
        CMD_OP    = 2'b10;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        RST = 1'b1;
        #1;
        check("rstx_pop_gated", 32'(STK_POP), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        check("rstx_valid", 32'(RSP_VALID), 32'd0);
        check("rstx_ready", 32'(CMD_READY), 32'd1);
        check("rstx_rsp_data", 32'(RSP_DATA), 32'd0);
        check("rstx_errcnt", 32'(ERR_CNT), 32'd0);
        @(posedge CLK); #1;
        check("rstx_no_stale", 32'(RSP_VALID), 32'd0);
        check("rstx_pop_pulses", 32'(pop_pulses - po0), 32'd0);

        do_cmd("peek_empty", 2'b11, 2'd0, 2'd0, 1'b1);
        check_errcnt("errcnt_peek_empty", 1);
        do_cmd("push_last", 2'b01, 2'd1, 2'd0, 1'b0);
        do_cmd("peek_last", 2'b11, 2'd2, 2'd1, 1'b0);
        check("final_depth", 32'(cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stack_seq.md
# stack_seq

Command sequencer directly upstream of the 2-bit `stack`. It accepts PUSH, POP, PEEK and NOP commands over a valid/ready handshake and drives the stack's PUSH, POP and DATA_IN strobes. It checks STK_FULL/STK_EMPTY before issuing anything, so an illegal strobe never reaches the stack. It returns one response per command (data plus an overflow/underflow error flag) over a second valid/ready handshake.

## Interface
- DATA_W, default 2: data width; must match the stack.
- ERR_W, default 8: error-counter width.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset. The stack's RST_N is driven from ~RST at integration.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_OP  in  2  opcode: 00 NOP, 01 PUSH, 10 POP, 11 PEEK.
- CMD_DATA  in  DATA_W  push operand.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  consumer takes the response.
- RSP_DATA  out  DATA_W  popped/peeked value; 0 for PUSH, NOP or error.
- RSP_ERR  out  1  1 = PUSH while full, or POP/PEEK while empty.
- STK_PUSH  out  1  one-cycle push strobe to the stack.
- STK_POP  out  1  one-cycle pop strobe to the stack.
- STK_DATA_IN  out  DATA_W  push data to the stack.
- STK_DATA_OUT  in  DATA_W  stack top-of-stack; valid while STK_EMPTY=0.
- STK_FULL  in  1  stack full flag.
- STK_EMPTY  in  1  stack empty flag.
- ERR_CNT  out  ERR_W  saturating error count (see Configuration).

## Operation
- Stack contract:
  - PUSH/POP are sampled on the rising edge.
  - STK_DATA_OUT shows the current top and is read in the same cycle POP is asserted.
  - The flags reflect the post-edge state by the following cycle.
- States:
  - IDLE: CMD_READY=1. On CMD_VALID&CMD_READY, latch op and data, go to EXEC.
  - EXEC: one cycle. Evaluate the latched op against the flags:
    - PUSH, not full: STK_PUSH=1, STK_DATA_IN=latched data, response err=0.
    - PUSH, full: no strobe, err=1.
    - POP, not empty: STK_POP=1, capture STK_DATA_OUT into the response, err=0.
    - POP, empty: no strobe, err=1, data 0.
    - PEEK: capture STK_DATA_OUT with no strobe; err=STK_EMPTY; data 0 when empty.
    - NOP: data 0, err=0.
    - Always go to RESP.
  - RESP: RSP_VALID=1, with RSP_DATA/RSP_ERR held stable. On RSP_READY go to IDLE.
- Ports per state:
  - CMD_READY is high only in IDLE.
  - STK_PUSH/STK_POP are high only in EXEC, and never both.
  - STK_DATA_IN holds the latched data at all times; 0 after reset.
- Response fields are registered at the EXEC→RESP edge.
- RSP_VALID never drops without RSP_READY.
- Reset values: state IDLE, CMD_READY=1 during the first post-reset cycle, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, STK_PUSH=0, STK_POP=0, STK_DATA_IN=0, ERR_CNT=0.

## Timing
- Command accepted at edge N → EXEC during cycle N+1 (strobe visible) → RSP_VALID from cycle N+2.
- Minimum of 3 cycles per command when RSP_READY is tied high.
- CMD_READY reasserts in the cycle after the response handshake.
- Back-to-back commands see updated flags, because at least one edge separates the strobe from the next EXEC.
- Reset mid-operation:
  - RST combinationally gates STK_PUSH/STK_POP low in the same cycle, so no strobe escapes during reset.
  - The next edge forces IDLE and discards any pending response. No response is ever produced for the aborted command.
- A CMD_VALID held during RESP is ignored until IDLE; the command must stay stable until accepted.

## Configuration
- STACK_SEQ_ERRCNT_EN defined: ERR_CNT increments by 1 at each EXEC→RESP edge with err=1 and saturates at 2^ERR_W−1. RST clears it.
- Not defined: ERR_CNT is tied to 0 and the counter logic is absent. All other behaviour is identical.

## Test plan
- Reset, then PUSH 2'b10 with RSP_READY=1 → STK_PUSH high exactly one cycle with STK_DATA_IN=2'b10; RSP_VALID 2 cycles after accept with RSP_ERR=0, RSP_DATA=0.
- PUSH 1,2,3 then POP ×3 → RSP_DATA 3,2,1 with RSP_ERR=0; STK_POP pulses once per POP.
- POP on an empty stack → no STK_POP pulse, RSP_ERR=1, RSP_DATA=0. With STACK_SEQ_ERRCNT_EN, ERR_CNT=1.
- Fill the stack until STK_FULL=1, then PUSH → no STK_PUSH pulse, RSP_ERR=1. PEEK afterwards returns the last pushed value with err=0 and the stack depth unchanged.
- RSP_READY held low for 5 cycles → RSP_VALID/RSP_DATA stable and CMD_READY low throughout; CMD_READY returns the cycle after RSP_READY.
- Assert RST during an EXEC cycle of a POP → no STK_POP pulse; RSP_VALID=0 and CMD_READY=1 after reset; no stale response.
